// File: rtl/aes_round_ctrl.sv
// ----------------------------------------------------------------------------
// aes_round_ctrl
//
// Round sequencer for an iterative AES core. It accepts one 128-bit block,
// steps it through an external combinational round unit Nr+1 times (one
// AddRoundKey-only round, Nr-1 middle rounds, one final round), and then
// presents the result on a valid/ready handshake. It does not handle keys;
// it only tells the round unit which round key to use.
//
// Parameters
//   Nk             key length in 32-bit words (4, 6 or 8); Nr = Nk + 6
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   in_valid       host offers a block
//   in_ready       controller can accept a block (IDLE, keys valid, no abort)
//   in_data        plaintext or ciphertext block
//   in_decrypt     direction, sampled on accept (1 = decrypt)
//   key_ready      round keys for the current key are valid
//   abort          cancel the block in flight
//   dp_state       state register, fed to the round unit
//   dp_round_type  0 = AddRoundKey only, 1 = middle round, 2 = final round
//   dp_decrypt     latched direction for the round unit
//   rk_idx         round-key index for the round unit
//   dp_result      round-unit output for the current dp_state
//   out_valid      result available
//   out_ready      host takes the result
//   out_data       result block
//   busy           controller is not IDLE
// ----------------------------------------------------------------------------
module aes_round_ctrl #(
    parameter int Nk = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_decrypt,
    input  logic         key_ready,
    input  logic         abort,
    output logic [127:0] dp_state,
    output logic [1:0]   dp_round_type,
    output logic         dp_decrypt,
    output logic [3:0]   rk_idx,
    input  logic [127:0] dp_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int         Nr = Nk + 6;
    localparam logic [3:0] NR = 4'(Nr);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] RT_ARK   = 2'd0;
    localparam logic [1:0] RT_MID   = 2'd1;
    localparam logic [1:0] RT_FINAL = 2'd2;

    logic [1:0]   fsm_q,   fsm_d;
    logic [3:0]   r_q,     r_d;
    logic [127:0] state_q, state_d;
    logic         dec_q,   dec_d;

    logic accept;

    // Reset is gated in so the host never sees a ready it cannot use.
    assign in_ready = (fsm_q == IDLE) && key_ready && !abort && !reset;
    assign accept   = in_valid && in_ready;

    // Next-state logic. abort outranks every other transition.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        fsm_d   = fsm_q;
        r_d     = r_q;
        state_d = state_q;
        dec_d   = dec_q;
        if (abort) begin
            fsm_d   = IDLE;
            r_d     = '0;
            state_d = '0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (accept) begin
                        fsm_d   = RUN;
                        r_d     = '0;
                        state_d = in_data;
                        dec_d   = in_decrypt;
                    end
                end
                RUN: begin
                    state_d = dp_result;
                    // r stops at Nr: the final round leaves to DONE instead
                    // of counting past the last key index.
                    if (r_q == NR) begin
                        fsm_d = DONE;
                    end else begin
                        r_d = r_q + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm_d = IDLE;
                        r_d   = '0;
                    end
                end
                default: begin
                    fsm_d = IDLE;
                    r_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (reset) begin
            fsm_q   <= IDLE;
            r_q     <= '0;
            state_q <= '0;
            dec_q   <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            r_q     <= r_d;
            state_q <= state_d;
            dec_q   <= dec_d;
        end
    end

    // Round-unit controls are only meaningful in RUN; elsewhere they rest at 0.
    always_comb begin
        dp_round_type = RT_ARK;
        rk_idx        = '0;
        if (fsm_q == RUN) begin
            if (r_q == 4'd0) begin
                dp_round_type = RT_ARK;
            end else if (r_q == NR) begin
                dp_round_type = RT_FINAL;
            end else begin
                dp_round_type = RT_MID;
            end
            // Decryption walks the key schedule backwards.
            rk_idx = dec_q ? (NR - r_q) : r_q;
        end
    end

    assign dp_state   = state_q;
    assign dp_decrypt = dec_q;
    assign busy       = (fsm_q != IDLE);
    assign out_valid  = (fsm_q == DONE);
    // Intermediate round states are never exposed on the result port.
    assign out_data   = out_valid ? state_q : '0;

endmodule
